// File: rtl/key_matrix_scan_ctrl.sv
// Column scanner, frame debouncer and key encoder for a 4-column x 5-row active-low key matrix.
// Rows are sampled once per column dwell; press/release decisions are taken once per full frame.
module key_matrix_scan_ctrl #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_row_in,
  output logic [3:0] key_col_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_multi
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {IDLE, DEB, HELD, REL} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        accept, release_key;

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [1:0]    acc_cnt, new_cnt;
  logic [4:0]    acc_code, new_code, row_code;
  logic [2:0]    row_n;
  logic [3:0]    sum_cnt;
  logic          sample, frame_end;
  logic [4:0]    frame_code;
  logic          frame_multi, frame_empty;

  assign sample    = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_idx == 2'd3);

  // Row decode for the column currently driven low.
  always_comb begin
    row_n    = 3'd0;
    row_code = 5'd0;
    for (int r = 0; r < 5; r++) begin
      if (!key_row_in[r]) begin
        row_n    = row_n + 3'd1;
        row_code = 5'(int'(col_idx) * 5 + r + 1);
      end
    end
  end

  // Frame view including the sample taken on this edge.
  always_comb begin
    sum_cnt     = 4'(acc_cnt) + 4'(row_n);
    new_cnt     = (sum_cnt >= 4'd3) ? 2'd3 : sum_cnt[1:0];
    new_code    = (row_n == 3'd1) ? row_code : acc_code;
    frame_code  = (new_cnt == 2'd1) ? new_code : 5'd0;
    frame_multi = (new_cnt >= 2'd2);
    frame_empty = (new_cnt == 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt     <= '0;
      col_idx     <= 2'd0;
      key_col_out <= 4'b1110;
      acc_cnt     <= 2'd0;
      acc_code    <= 5'd0;
      key_multi   <= 1'b0;
    end else if (sample) begin
      div_cnt     <= '0;
      col_idx     <= col_idx + 2'd1;
      key_col_out <= ~(4'b0001 << (col_idx + 2'd1));
      if (col_idx == 2'd3) begin
        acc_cnt   <= 2'd0;
        acc_code  <= 5'd0;
        key_multi <= frame_multi;
      end else begin
        acc_cnt   <= new_cnt;
        acc_code  <= new_code;
      end
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

  // Debounce FSM; only frame-end edges can move it.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    release_key = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE: if (frame_code != 5'd0) begin
          cand_d = frame_code;
          cnt_d  = 4'd1;
          if (DEBOUNCE_CNT == 1) accept = 1'b1;
          else                   state_d = DEB;
        end
        DEB: if (frame_code == cand_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == DEB_TARGET) accept = 1'b1;
        end else begin
          state_d = IDLE;
        end
        HELD: if (frame_code != cand_q) begin
          state_d = REL;
          cnt_d   = frame_empty ? 4'd1 : 4'd0;
          if (frame_empty && DEBOUNCE_CNT == 1) release_key = 1'b1;
        end
        REL: if (frame_empty) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == DEB_TARGET) release_key = 1'b1;
        end else begin
          cnt_d = 4'd0;
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept)      state_d = HELD;
    if (release_key) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cand_q    <= 5'd0;
      cnt_q     <= 4'd0;
      key_code  <= 5'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      key_valid <= accept;
      if (accept) begin
        key_code <= cand_d;
        key_held <= 1'b1;
      end else if (release_key) begin
        key_held <= 1'b0;
      end
    end
  end

endmodule

// File: doc/key_matrix_scan_ctrl.md
Name: key_matrix_scan_ctrl

Overview:
- Scan controller for the 4-column x 5-row active-low key matrix.
- Drives one column low at a time and samples the 5 row lines at the end of each column dwell.
- Debounces across full scan frames, encodes the pressed key as 1..20, and emits a one-cycle valid pulse per debounced press.
- Sits between the keypad (or keypad simulation model) and the 7-segment display logic.

Parameters:
- SCAN_DIV, 1000, clk cycles per column dwell (100 us at 10 MHz); legal range >= 4.
- DEBOUNCE_CNT, 4, consecutive identical frames needed to accept a press or a release; legal range 1..15.

Ports:
- clk  input  1  10 MHz system clock
- rst  input  1  asynchronous active-low reset
- key_row_in  input  5  active-low row lines; bit r low = key in row r of the driven column
- key_col_out  output  4  active-low one-hot column drive
- key_code  output  5  last accepted key, col*5+row+1 (1..20); 0 = none since reset
- key_valid  output  1  one-cycle pulse when key_code is updated
- key_held  output  1  high while the accepted key is still pressed
- key_multi  output  1  high while the last completed frame saw more than one key

Behaviour:
- Reset is asynchronous, active-low; clock is clk. Reset values:
  - key_col_out = 4'b1110
  - key_code = 0, key_valid = 0, key_held = 0, key_multi = 0
  - dwell counter = 0, column index = 0, FSM = IDLE, all frame accumulators cleared
- Column sequencing:
  - Dwell counter runs 0..SCAN_DIV-1. Rows are sampled only on the cycle where count == SCAN_DIV-1, tolerating one or more cycles of row-path latency.
  - On the same edge, the column index advances 0->1->2->3->0 and key_col_out becomes 1110, 1101, 1011, 0111 respectively.
  - One frame = 4*SCAN_DIV cycles.
- Frame accumulation:
  - At each sample, count the low bits of key_row_in and add to a saturating 2-bit press count.
  - If exactly one bit is low at bit r, record code = col*5+r+1.
  - After sampling column 3 (frame end), evaluate the frame:
    - count 0 -> frame_code = 0
    - count 1 -> frame_code = recorded code
    - count >= 2 -> frame_multi = 1, frame_code = 0
  - Clear the accumulators for the next frame. key_multi is registered from frame_multi at each frame end.
- FSM, evaluated only at frame end:
  - IDLE: if frame_code != 0, set cand = frame_code, cnt = 1. If DEBOUNCE_CNT == 1, accept immediately; otherwise go to DEB.
  - DEB: if frame_code == cand, increment cnt; when cnt reaches DEBOUNCE_CNT, accept. Otherwise (different key, empty frame, or multi), go to IDLE.
  - Accept: key_code <= cand, key_valid = 1 for exactly one clk (the cycle after the frame-end edge), key_held <= 1, go to HELD.
  - HELD: if frame_code == cand, stay. Otherwise go to REL with rcnt = 1 if the frame is empty, else rcnt = 0.
  - REL: an empty frame increments rcnt; a non-empty frame (any key, including multi) clears rcnt to 0. When rcnt reaches DEBOUNCE_CNT, key_held <= 0 and go to IDLE.
    - The same key returning in REL does not re-pulse key_valid.
    - A new key pressed during REL is not reported until release completes and the key is debounced from IDLE.
- Press latency: a key stable from the start of frame k produces key_valid one cycle after the end of frame k+DEBOUNCE_CNT-1.
- key_code holds its value across release; it changes only on accept.
- Reset mid-operation aborts the frame and FSM immediately; scanning restarts at column 0 with dwell count 0.
- Row lines are assumed synchronous to clk; no extra synchronizer is included.

Test Plan (key_pad simulation model on key_col_out/key_row_in, SCAN_DIV=4, DEBOUNCE_CNT=2, frame = 16 clk):
- Reset held low then released, key_v=0:
  - All outputs at reset values.
  - key_col_out cycles 1110, 1101, 1011, 0111 with 4 clk each.
  - No key_valid after 10 frames.
- key_v=8 (column 1, row 2) from frame start:
  - key_valid pulses once at the end of frame 2.
  - key_code = 8, key_held = 1, key_multi = 0.
  - Hold 10 frames: no further pulses.
- Release after the previous case (key_v=0):
  - key_held falls at the end of the 2nd empty frame.
  - key_code stays 8; no key_valid.
  - Re-press key_v=1 -> key_code = 1 after 2 frames.
- Bounce, key_v=20 for one frame, then 0, then 20 for one frame: no key_valid. Follow with key_v=20 held 2 frames -> key_code = 20.
- key_v=21 (two keys in column 0):
  - key_multi = 1 from the first frame end; no key_valid.
  - Setting key_v=25 gives key_multi = 0 at the next frame end, and no press.
- Reset asserted mid-DEB (key_v=13, 1 frame in):
  - Outputs return to reset values.
  - After release, key_code = 13 at the end of the 2nd full frame.
